if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 27 ++
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage_next_pc.sv | 36 +++
 rtl/if_stage.sv | 148 ++++++++++++++
 tb/tb_if_stage.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: pcsource codes, bubble encoding,
// instruction field positions and the IF state type.
package cpu_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_ILL = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    HALT  = 2'b10
  } if_state_t;

  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundles the fetch stage's control inputs, instruction-memory handshake and IF/ID outputs.
// The fetch stage takes the master view; the surrounding CPU/testbench takes the slave view.
interface if_stage_if;

  logic        stall;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        halted;

  modport master (
    input  stall, pcsource, bpc, jpc, imem_ready, imem_rdata,
    output imem_req, imem_addr, id_inst, id_pc4, id_valid, op, func, halted
  );

  modport slave (
    output stall, pcsource, bpc, jpc, imem_ready, imem_rdata,
    input  imem_req, imem_addr, id_inst, id_pc4, id_valid, op, func, halted
  );

endinterface

// File: rtl/if_stage_next_pc.sv
// Combinational next-PC selection: decodes pcsource into redirect/illegal flags and
// picks the PC to load when the current fetch completes.
module if_next_pc
  import cpu_pkg::*;
(
  input  logic        i_stall,
  input  logic [1:0]  i_pcsource,
  input  logic [31:0] i_bpc,
  input  logic [31:0] i_jpc,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pending,
  input  if_state_t   i_state,
  output logic [31:0] o_pcPlus4,
  output logic [31:0] o_target,
  output logic [31:0] o_nextPc,
  output logic        o_redirect,
  output logic        o_illegal
);

  always_comb begin
    o_pcPlus4  = i_pc + 32'd4;
    o_redirect = !i_stall && (i_pcsource != PCSRC_SEQ);
    o_illegal  = !i_stall && (i_pcsource == PCSRC_ILL);
    case (i_pcsource)
      PCSRC_J: o_target = alignWord(i_jpc);
      default: o_target = alignWord(i_bpc);
    endcase
    // A fresh redirect always wins over a target parked while draining.
    o_nextPc = o_pcPlus4;
    if (o_redirect)
      o_nextPc = o_target;
    else if (i_state == DRAIN)
      o_nextPc = i_pending;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/bubble counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        resetn,
  if_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);
  import cpu_pkg::*;

  if_state_t   r_state, w_stateNext;
  logic [31:0] r_pc, w_pcNext;
  logic [31:0] r_pending, w_pendingNext;
  logic [31:0] r_idInst, r_idPc4;
  logic        r_idValid;
  logic        w_req, w_loadFetch, w_loadBubble;
  logic [31:0] w_pcPlus4, w_target, w_nextPc;
  logic        w_redirect, w_illegal;

  if_next_pc u_nextPc (
    .i_stall    (bus.stall),
    .i_pcsource (bus.pcsource),
    .i_bpc      (bus.bpc),
    .i_jpc      (bus.jpc),
    .i_pc       (r_pc),
    .i_pending  (r_pending),
    .i_state    (r_state),
    .o_pcPlus4  (w_pcPlus4),
    .o_target   (w_target),
    .o_nextPc   (w_nextPc),
    .o_redirect (w_redirect),
    .o_illegal  (w_illegal)
  );

  always_comb begin
    w_stateNext   = r_state;
    w_pcNext      = r_pc;
    w_pendingNext = r_pending;
    w_req         = 1'b0;
    w_loadFetch   = 1'b0;
    w_loadBubble  = 1'b0;
    case (r_state)
      RUN: begin
        w_req = !bus.stall;
        if (!bus.stall) begin
          if (w_illegal) begin
            w_stateNext  = HALT;
            w_loadBubble = 1'b1;
          end else if (w_redirect) begin
            w_loadBubble = 1'b1;
            if (bus.imem_ready) begin
              w_pcNext = w_nextPc;
            end else begin
              // Request is outstanding: keep the address and remember where to go.
              w_pendingNext = w_target;
              w_stateNext   = DRAIN;
            end
          end else if (bus.imem_ready) begin
            w_loadFetch = 1'b1;
            w_pcNext    = w_nextPc;
          end else begin
            w_loadBubble = 1'b1;
          end
        end
      end
      DRAIN: begin
        w_req        = 1'b1;
        w_loadBubble = 1'b1;
        if (w_illegal) begin
          w_stateNext = HALT;
        end else begin
          if (w_redirect)
            w_pendingNext = w_target;
          if (bus.imem_ready) begin
            w_pcNext    = w_nextPc;
            w_stateNext = RUN;
          end
        end
      end
      HALT: begin
        w_loadBubble = 1'b1;
      end
      default: begin
        w_loadBubble = 1'b1;
        w_stateNext  = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= RUN;
      r_pc      <= RESET_PC;
      r_pending <= '0;
      r_idInst  <= NOP_INST;
      r_idPc4   <= '0;
      r_idValid <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_pending <= w_pendingNext;
      if (w_loadFetch) begin
        r_idInst  <= bus.imem_rdata;
        r_idPc4   <= w_pcPlus4;
        r_idValid <= 1'b1;
      end else if (w_loadBubble) begin
        r_idInst  <= NOP_INST;
        r_idValid <= 1'b0;
      end
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = alignWord(r_pc);
  assign bus.id_inst   = r_idInst;
  assign bus.id_pc4    = r_idPc4;
  assign bus.id_valid  = r_idValid;
  assign bus.op        = r_idInst[OP_MSB:OP_LSB];
  assign bus.func      = r_idInst[FUNC_MSB:FUNC_LSB];
  assign bus.halted    = (r_state == HALT);

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetchCnt, r_bubbleCnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fetchCnt  <= '0;
      r_bubbleCnt <= '0;
    end else begin
      if (w_loadFetch && (r_fetchCnt != 32'hFFFF_FFFF))
        r_fetchCnt <= r_fetchCnt + 32'd1;
      if (w_loadBubble && (r_bubbleCnt != 32'hFFFF_FFFF))
        r_bubbleCnt <= r_bubbleCnt + 32'd1;
    end
  end

  assign perf_fetch_cnt  = r_fetchCnt;
  assign perf_bubble_cnt = r_bubbleCnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard testbench for if_stage: directed scenarios followed by random stimulus,
// checked against a behavioural fetch model (IF_PERF_CNT_EN also checks the counters).
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic resetn;
  if_stage_if bus();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perfFetchCnt, perfBubbleCnt;
`endif

  if_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt  (perfFetchCnt),
    .perf_bubble_cnt (perfBubbleCnt),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F96;
  endfunction

  assign bus.imem_rdata = bus.imem_ready ? memWord(bus.imem_addr) : 32'hBAD0_BAD0;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        halted;
  } expEntry_t;

  expEntry_t sbQ[$];
  expEntry_t monEntry;
  int nChecks;
  int nFails;

  // Behavioural view: where the fetch pointer is, whether a redirect is waiting
  // for an outstanding fetch to retire, and what ID should be holding.
  logic [31:0] mPc;
  logic [31:0] mTarget;
  bit          mDraining;
  bit          mHalted;
  expEntry_t   mId;
  int unsigned mFetchCnt;
  int unsigned mBubbleCnt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelBubble();
    mId.valid = 1'b0;
    mId.inst  = 32'h0;
    mBubbleCnt++;
  endtask

  task automatic modelStep(input bit rn, input bit st, input logic [1:0] ps,
                           input logic [31:0] b, input logic [31:0] j, input bit rdy);
    logic [31:0] tgt;
    tgt = (ps == 2'b10) ? {j[31:2], 2'b00} : {b[31:2], 2'b00};
    if (!rn) begin
      mPc        = RESET_PC;
      mDraining  = 0;
      mHalted    = 0;
      mId.valid  = 1'b0;
      mId.inst   = 32'h0;
      mId.pc4    = 32'h0;
      mFetchCnt  = 0;
      mBubbleCnt = 0;
    end else if (mHalted) begin
      modelBubble();
    end else if (!st && ps == 2'b11) begin
      mHalted = 1;
      modelBubble();
    end else if (mDraining) begin
      if (!st && ps != 2'b00) mTarget = tgt;
      modelBubble();
      if (rdy) begin
        mPc       = mTarget;
        mDraining = 0;
      end
    end else if (st) begin
      // frozen: nothing moves
    end else if (ps != 2'b00) begin
      modelBubble();
      if (rdy) mPc = tgt;
      else begin
        mTarget   = tgt;
        mDraining = 1;
      end
    end else if (rdy) begin
      mId.valid = 1'b1;
      mId.inst  = memWord(mPc);
      mId.pc4   = mPc + 32'd4;
      mPc       = mPc + 32'd4;
      mFetchCnt++;
    end else begin
      modelBubble();
    end
    mId.halted = mHalted;
    sbQ.push_back(mId);
  endtask

  task automatic applyStimulus(input bit rn, input bit st, input logic [1:0] ps,
                               input logic [31:0] b, input logic [31:0] j, input bit rdy);
    bit expReq;
    resetn         = rn;
    bus.stall      = st;
    bus.pcsource   = ps;
    bus.bpc        = b;
    bus.jpc        = j;
    bus.imem_ready = rdy;
    #1;
    if (rn) begin
      expReq = !mHalted && (mDraining || !st);
      checkOutput("imem_req", {31'b0, bus.imem_req}, {31'b0, expReq});
      if (expReq) checkOutput("imem_addr", bus.imem_addr, mPc);
    end
    @(posedge clk);
    modelStep(rn, st, ps, b, j, rdy);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      monEntry = sbQ.pop_front();
      checkOutput("sb_id_valid", {31'b0, bus.id_valid}, {31'b0, monEntry.valid});
      checkOutput("sb_halted", {31'b0, bus.halted}, {31'b0, monEntry.halted});
      if (monEntry.valid) begin
        checkOutput("sb_id_inst", bus.id_inst, monEntry.inst);
        checkOutput("sb_id_pc4", bus.id_pc4, monEntry.pc4);
        checkOutput("sb_op", {26'b0, bus.op}, {26'b0, monEntry.inst[31:26]});
        checkOutput("sb_func", {26'b0, bus.func}, {26'b0, monEntry.inst[5:0]});
      end
    end
  end

  initial begin
    nChecks        = 0;
    nFails         = 0;
    resetn         = 1'b0;
    bus.stall      = 1'b0;
    bus.pcsource   = 2'b00;
    bus.bpc        = 32'h0;
    bus.jpc        = 32'h0;
    bus.imem_ready = 1'b0;
    mPc = RESET_PC; mTarget = 0; mDraining = 0; mHalted = 0;
    mId.valid = 0; mId.inst = 0; mId.pc4 = 0; mId.halted = 0;
    mFetchCnt = 0; mBubbleCnt = 0;
    @(negedge clk);

    $display("[TB] reset and sequential fetch");
    applyStimulus(0, 0, 2'b00, 0, 0, 1);
    applyStimulus(0, 0, 2'b00, 0, 0, 1);
    checkOutput("rst_id_valid", {31'b0, bus.id_valid}, 32'h0);
    checkOutput("rst_id_inst", bus.id_inst, 32'h0);
    checkOutput("rst_id_pc4", bus.id_pc4, 32'h0);
    checkOutput("rst_halted", {31'b0, bus.halted}, 32'h0);
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    checkOutput("seq0_pc4", bus.id_pc4, 32'h4);
    checkOutput("seq0_inst", bus.id_inst, memWord(32'h0));
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    checkOutput("seq2_pc4", bus.id_pc4, 32'hC);
    checkOutput("seq2_inst", bus.id_inst, memWord(32'h8));

    $display("[TB] branch with same-cycle ready");
    applyStimulus(1, 0, 2'b01, 32'h0000_0043, 0, 1);
    checkOutput("br_bubble", {31'b0, bus.id_valid}, 32'h0);
    checkOutput("br_addr", bus.imem_addr, 32'h40);
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    checkOutput("br_fetch_pc4", bus.id_pc4, 32'h44);

    $display("[TB] jump while memory waits");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 2'b10, 0, 32'h100, 0);
      checkOutput("drain_addr", bus.imem_addr, 32'h44);
      checkOutput("drain_bubble", {31'b0, bus.id_valid}, 32'h0);
    end
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    checkOutput("drain_done_bubble", {31'b0, bus.id_valid}, 32'h0);
    checkOutput("drain_done_addr", bus.imem_addr, 32'h100);
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    checkOutput("jmp_fetch_pc4", bus.id_pc4, 32'h104);
`ifdef IF_PERF_CNT_EN
    checkOutput("perf_fetch_s123", perfFetchCnt, 32'd5);
    checkOutput("perf_bubble_s123", perfBubbleCnt, 32'd5);
`endif

    $display("[TB] stall holds");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1, 2'b01, 32'h800, 0, 1);
      checkOutput("stall_inst", bus.id_inst, memWord(32'h100));
      checkOutput("stall_pc4", bus.id_pc4, 32'h104);
      checkOutput("stall_addr", bus.imem_addr, 32'h104);
    end
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    checkOutput("resume_pc4", bus.id_pc4, 32'h108);

    $display("[TB] illegal pcsource halts");
    applyStimulus(1, 0, 2'b11, 0, 0, 1);
    checkOutput("halt_flag", {31'b0, bus.halted}, 32'h1);
    checkOutput("halt_req", {31'b0, bus.imem_req}, 32'h0);
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    checkOutput("halt_valid", {31'b0, bus.id_valid}, 32'h0);
    applyStimulus(0, 0, 2'b00, 0, 0, 1);
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    checkOutput("unhalt_flag", {31'b0, bus.halted}, 32'h0);
    checkOutput("unhalt_pc4", bus.id_pc4, RESET_PC + 32'd4);

    $display("[TB] PC wrap");
    applyStimulus(1, 0, 2'b10, 0, 32'hFFFF_FFFF, 1);
    checkOutput("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    checkOutput("wrap_pc4", bus.id_pc4, 32'h0);
    checkOutput("wrap_inst", bus.id_inst, memWord(32'hFFFF_FFFC));
    checkOutput("wrap_addr", bus.imem_addr, 32'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      int r;
      bit rn, st, rdy;
      logic [1:0] ps;
      r   = $urandom_range(0, 99);
      ps  = (r < 70) ? 2'b00 : (r < 84) ? 2'b01 : (r < 98) ? 2'b10 : 2'b11;
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      rn  = !(mHalted && $urandom_range(0, 3) == 0) && ($urandom_range(0, 99) != 0);
      applyStimulus(rn, st, ps, $urandom, $urandom, rdy);
    end
`ifdef IF_PERF_CNT_EN
    checkOutput("perf_fetch_rand", perfFetchCnt, mFetchCnt);
    checkOutput("perf_bubble_rand", perfBubbleCnt, mBubbleCnt);
`endif

    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
